// File: rtl/if_stage1_pkg.sv
// Shared widths, bus payload layouts and FSM encoding for the IF1 fetch stage.
package if_stage1_pkg;

  localparam int unsigned IF0_TO_IF1_BUS_WD = 40;
  localparam int unsigned IF1_TO_ID_BUS_WD  = 168;
  localparam int unsigned QDEPTH            = 2;
  localparam int unsigned PTR_W             = 1;
  localparam int unsigned CNT_W             = 2;
  localparam int unsigned SUM_W             = 3;
  localparam int unsigned PC_W              = 32;
  localparam int unsigned INST_W            = 32;
  localparam int unsigned DATA_W            = 128;

  // Field offsets inside the IF1->ID packet.
  localparam int unsigned PKT_INST0_LSB = 0;
  localparam int unsigned PKT_PC_LSB    = DATA_W;
  localparam int unsigned PKT_JUMP_LSB  = DATA_W + PC_W;
  localparam int unsigned PKT_VALID_LSB = DATA_W + PC_W + 4;

  localparam logic [CNT_W-1:0] DISCARD_MAX = CNT_W'(2);

  // IF0 request metadata, laid out exactly as if0_if1_bus.
  typedef struct packed {
    logic [3:0]      pc_valid;
    logic [3:0]      pc_is_jump;
    logic [PC_W-1:0] pc;
  } if0_meta_t;

  // Fetch packet, laid out exactly as if1_id_bus (inst0 in the low word).
  typedef struct packed {
    if0_meta_t         meta;
    logic [DATA_W-1:0] inst;
  } if1_pkt_t;

  // One fetch-queue slot.
  typedef struct packed {
    if0_meta_t         meta;
    logic [DATA_W-1:0] data;
    logic              data_valid;
  } qentry_t;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_DRAIN  = 1'b1
  } state_e;

  // Clamp a discard total to the maximum number of responses that can be owed.
  function automatic logic [CNT_W-1:0] sat_disc(input logic [SUM_W-1:0] x);
    return (x > SUM_W'(DISCARD_MAX)) ? DISCARD_MAX : x[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/if_stage1_if.sv
// IF0 / cache / ID facing signals of the IF1 stage.
interface if_stage1_if;
  import if_stage1_pkg::*;

  logic                         flush_IF;
  logic                         IF0_valid;
  logic                         IF1_ready;
  logic [IF0_TO_IF1_BUS_WD-1:0] if0_if1_bus;
  logic                         data_ok;
  logic [DATA_W-1:0]            rdata;
  logic                         IF1_valid;
  logic [IF1_TO_ID_BUS_WD-1:0]  if1_id_bus;
  logic                         ID_ready;

  modport slave (
    input  flush_IF, IF0_valid, if0_if1_bus, data_ok, rdata, ID_ready,
    output IF1_ready, IF1_valid, if1_id_bus
  );

  modport master (
    output flush_IF, IF0_valid, if0_if1_bus, data_ok, rdata, ID_ready,
    input  IF1_ready, IF1_valid, if1_id_bus
  );

endinterface

// File: rtl/if_stage1_fetch_queue.sv
// Two-entry in-order queue pairing request metadata with cache data.
module if_stage1_fetch_queue
  import if_stage1_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              cap_i,
  input  if0_meta_t         cap_meta_i,
  input  logic              fill_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              id_ready_i,
  output logic              pkt_valid_o,
  output if1_pkt_t          pkt_o,
  output logic [CNT_W-1:0]  used_nxt_c,
  output logic [CNT_W-1:0]  awaiting_c
);

  qentry_t           mem_q [QDEPTH];
  qentry_t           mem_d [QDEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]  used_q, used_d;
  logic [CNT_W-1:0]  dv_cnt;
  logic              pop_c;
  qentry_t           head_ent;
  qentry_t           nxt_ent;
  logic              pkt_valid_q;
  if1_pkt_t          pkt_q;

  // Occupied entries still waiting for their cache response.
  always_comb begin
    dv_cnt = '0;
    for (int i = 0; i < int'(QDEPTH); i++) begin
      dv_cnt = dv_cnt + CNT_W'(mem_q[i].data_valid);
    end
    awaiting_c = used_q - dv_cnt;
  end

  // Next queue state: pop (ID accept or bubble retire), fill, capture; flush wins.
  always_comb begin
    for (int i = 0; i < int'(QDEPTH); i++) begin
      mem_d[i] = mem_q[i];
    end
    head_d   = head_q;
    tail_d   = tail_q;
    fill_d   = fill_q;
    used_d   = used_q;
    head_ent = mem_q[head_q];
    pop_c    = head_ent.data_valid && ((head_ent.meta.pc_valid == '0) || id_ready_i);
    if (flush_i) begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        mem_d[i] = '0;
      end
      head_d = '0;
      tail_d = '0;
      fill_d = '0;
      used_d = '0;
    end else begin
      if (pop_c) begin
        mem_d[head_q].data_valid = 1'b0;
        head_d = head_q + PTR_W'(1);
      end
      if (fill_i && (awaiting_c != '0)) begin
        mem_d[fill_q].data       = fill_data_i;
        mem_d[fill_q].data_valid = 1'b1;
        fill_d = fill_q + PTR_W'(1);
      end
      if (cap_i) begin
        mem_d[tail_q].meta       = cap_meta_i;
        mem_d[tail_q].data       = '0;
        mem_d[tail_q].data_valid = 1'b0;
        tail_d = tail_q + PTR_W'(1);
      end
      used_d = used_q + CNT_W'(cap_i) - CNT_W'(pop_c);
    end
    used_nxt_c = used_d;
    nxt_ent    = mem_d[head_d];
  end

  // Queue state and registered view of the next head packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        mem_q[i] <= '0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      fill_q      <= '0;
      used_q      <= '0;
      pkt_valid_q <= 1'b0;
      pkt_q       <= '0;
    end else begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
      head_q      <= head_d;
      tail_q      <= tail_d;
      fill_q      <= fill_d;
      used_q      <= used_d;
      pkt_valid_q <= nxt_ent.data_valid && (nxt_ent.meta.pc_valid != '0);
      pkt_q.meta  <= nxt_ent.meta;
      pkt_q.inst  <= nxt_ent.data;
    end
  end

  assign pkt_valid_o = pkt_valid_q;
  assign pkt_o       = pkt_q;

endmodule

// File: rtl/if_stage1.sv
// IF1 fetch stage: request handshake, flush discard accounting and drain FSM.
module if_stage1
  import if_stage1_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  if_stage1_if.slave  bus
);

  logic             cap_pend_q, cap_pend_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] disc_q, disc_d;
  state_e           state_q, state_d;
  logic             accept_c;
  logic             capture_c;
  logic             fill_c;
  logic [SUM_W-1:0] disc_sum;
  logic [CNT_W-1:0] used_nxt_c;
  logic [CNT_W-1:0] awaiting_c;
  logic             pkt_valid;
  if1_pkt_t         pkt;

  if_stage1_fetch_queue u_queue (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (bus.flush_IF),
    .cap_i       (capture_c),
    .cap_meta_i  (if0_meta_t'(bus.if0_if1_bus)),
    .fill_i      (fill_c),
    .fill_data_i (bus.rdata),
    .id_ready_i  (bus.ID_ready),
    .pkt_valid_o (pkt_valid),
    .pkt_o       (pkt),
    .used_nxt_c  (used_nxt_c),
    .awaiting_c  (awaiting_c)
  );

  // Request acceptance, capture, fill and ready for the next cycle.
  always_comb begin
    accept_c   = bus.IF0_valid && ready_q && !bus.flush_IF;
    cap_pend_d = accept_c;
    capture_c  = cap_pend_q && !bus.flush_IF;
    fill_c     = bus.data_ok && (disc_q == '0) && !bus.flush_IF;
    ready_d    = (SUM_W'(used_nxt_c) + SUM_W'(cap_pend_d)) < SUM_W'(2);
  end

  // Responses owed to flushed requests; a response in the flush cycle is one of them.
  always_comb begin
    disc_d   = disc_q;
    disc_sum = SUM_W'(disc_q) + SUM_W'(awaiting_c) + SUM_W'(cap_pend_q);
    if (bus.flush_IF) begin
      if (bus.data_ok && (disc_sum != '0)) begin
        disc_sum = disc_sum - SUM_W'(1);
      end
      disc_d = sat_disc(disc_sum);
    end else if (bus.data_ok && (disc_q != '0)) begin
      disc_d = disc_q - CNT_W'(1);
    end
  end

  // Drain FSM next state: stay in DRAIN while responses are still owed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL: if (disc_d != '0) state_d = ST_DRAIN;
      ST_DRAIN:  if (disc_d == '0) state_d = ST_NORMAL;
      default:   state_d = ST_NORMAL;
    endcase
  end

  // Handshake, discard counter and FSM state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_pend_q <= 1'b0;
      ready_q    <= 1'b1;
      disc_q     <= '0;
      state_q    <= ST_NORMAL;
    end else begin
      cap_pend_q <= cap_pend_d;
      ready_q    <= ready_d;
      disc_q     <= disc_d;
      state_q    <= state_d;
    end
  end

  assign bus.IF1_ready  = ready_q;
  assign bus.IF1_valid  = pkt_valid;
  assign bus.if1_id_bus = pkt;

  // A response outside a discard window must find an entry waiting for it.
  assert property (@(posedge clk) disable iff (rst)
    (bus.data_ok && !bus.flush_IF && (disc_q == '0)) |-> (awaiting_c != '0));

endmodule

// File: tb/tb_if_stage1.sv
// Directed bench for if_stage1: per-cycle vector table plus flush/reset sequences.
module tb_if_stage1;
  import if_stage1_pkg::*;

  typedef struct {
    logic        v;
    logic [39:0] meta;
    logic        dok;
    logic [31:0] tag;
    logic        idr;
    logic        rdy;
    logic        val;
    logic [31:0] pc;
    logic [31:0] i0;
  } vec_t;

  localparam int NV = 21;
  localparam logic [31:0] PA = 32'h1c000000, PB = 32'h1c000010;
  localparam logic [31:0] PC_ = 32'h1c000020, PD = 32'h1c000030;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  vec_t tbl [NV];

  if_stage1_if bus_if ();

  if_stage1 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] m(input logic [3:0] pv, input logic [3:0] pj, input logic [31:0] pc);
    return {pv, pj, pc};
  endfunction

  function automatic logic [127:0] rd(input logic [31:0] t);
    return {t + 32'd3, t + 32'd2, t + 32'd1, t};
  endfunction

  function automatic vec_t mk(input logic v, input logic [39:0] meta, input logic dok,
                              input logic [31:0] tag, input logic idr, input logic rdy,
                              input logic val, input logic [31:0] pc, input logic [31:0] i0);
    vec_t r;
    r.v = v; r.meta = meta; r.dok = dok; r.tag = tag; r.idr = idr;
    r.rdy = rdy; r.val = val; r.pc = pc; r.i0 = i0;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [167:0] act, input logic [167:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [39:0] meta, input logic dok,
                       input logic [31:0] tag, input logic idr, input logic fl);
    bus_if.IF0_valid   = v;
    bus_if.if0_if1_bus = meta;
    bus_if.data_ok     = dok;
    bus_if.rdata       = dok ? rd(tag) : 128'h0;
    bus_if.ID_ready    = idr;
    bus_if.flush_IF    = fl;
  endtask

  // Drive one cycle of inputs, then sample just after the edge.
  task automatic cyc(input logic v, input logic [39:0] meta, input logic dok,
                     input logic [31:0] tag, input logic idr, input logic fl);
    drive(v, meta, dok, tag, idr, fl);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pkt(input string nm, input logic [31:0] pc, input logic [31:0] i0);
    chk({nm, " valid"}, 168'(bus_if.IF1_valid), 168'(1'b1));
    chk({nm, " pc"}, 168'(bus_if.if1_id_bus[PKT_PC_LSB +: 32]), 168'(pc));
    chk({nm, " inst0"}, 168'(bus_if.if1_id_bus[PKT_INST0_LSB +: 32]), 168'(i0));
  endtask

  initial begin
    // Single fetch, back-pressure with ignored third request, bubble retire.
    tbl[0]  = mk(1, 40'h0,             0, 0,     1, 1, 0, 0,  0);
    tbl[1]  = mk(0, m(4'hF, 0, PA),    0, 0,     1, 1, 0, 0,  0);
    tbl[2]  = mk(0, 40'h0,             0, 0,     1, 1, 0, 0,  0);
    tbl[3]  = mk(0, 40'h0,             1, 0,     0, 1, 1, PA, 32'h0);
    tbl[4]  = mk(0, 40'h0,             0, 0,     0, 1, 1, PA, 32'h0);
    tbl[5]  = mk(0, 40'h0,             0, 0,     1, 1, 0, 0,  0);
    tbl[6]  = mk(1, 40'h0,             0, 0,     0, 1, 0, 0,  0);
    tbl[7]  = mk(1, m(4'hF, 0, PA),    0, 0,     0, 0, 0, 0,  0);
    tbl[8]  = mk(1, m(4'hF, 0, PB),    0, 0,     0, 0, 0, 0,  0);
    tbl[9]  = mk(1, m(4'hF, 5, 32'hdeadbeef), 1, 32'h10, 0, 0, 1, PA, 32'h10);
    tbl[10] = mk(1, 40'h0,             1, 32'h20, 0, 0, 1, PA, 32'h10);
    tbl[11] = mk(0, 40'h0,             0, 0,     1, 1, 1, PB, 32'h20);
    tbl[12] = mk(0, 40'h0,             0, 0,     0, 1, 1, PB, 32'h20);
    tbl[13] = mk(0, 40'h0,             0, 0,     1, 1, 0, 0,  0);
    tbl[14] = mk(1, 40'h0,             0, 0,     0, 1, 0, 0,  0);
    tbl[15] = mk(1, m(4'h0, 0, PC_),   0, 0,     0, 0, 0, 0,  0);
    tbl[16] = mk(0, m(4'hF, 0, PD),    0, 0,     0, 0, 0, 0,  0);
    tbl[17] = mk(0, 40'h0,             1, 32'h30, 0, 0, 0, 0,  0);
    tbl[18] = mk(0, 40'h0,             0, 0,     0, 1, 0, 0,  0);
    tbl[19] = mk(0, 40'h0,             1, 32'h40, 0, 1, 1, PD, 32'h40);
    tbl[20] = mk(0, 40'h0,             0, 0,     1, 1, 0, 0,  0);

    drive(0, 40'h0, 0, 0, 1, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset valid", 168'(bus_if.IF1_valid), 168'(1'b0));
    chk("reset bus", bus_if.if1_id_bus, 168'h0);
    chk("reset ready", 168'(bus_if.IF1_ready), 168'(1'b1));

    for (int i = 0; i < NV; i++) begin
      cyc(tbl[i].v, tbl[i].meta, tbl[i].dok, tbl[i].tag, tbl[i].idr, 1'b0);
      chk($sformatf("row%0d ready", i), 168'(bus_if.IF1_ready), 168'(tbl[i].rdy));
      chk($sformatf("row%0d valid", i), 168'(bus_if.IF1_valid), 168'(tbl[i].val));
      if (tbl[i].val) begin
        chk($sformatf("row%0d pc", i), 168'(bus_if.if1_id_bus[PKT_PC_LSB +: 32]), 168'(tbl[i].pc));
        chk($sformatf("row%0d inst0", i), 168'(bus_if.if1_id_bus[PKT_INST0_LSB +: 32]), 168'(tbl[i].i0));
      end
    end

    // Flush with two outstanding requests, then a fresh request during drain.
    cyc(1, 40'h0, 0, 0, 1, 0);
    cyc(1, m(4'hF, 0, 32'h1c000100), 0, 0, 1, 0);
    cyc(0, m(4'hF, 0, 32'h1c000110), 0, 0, 1, 0);
    chk("fl2 full ready", 168'(bus_if.IF1_ready), 168'(1'b0));
    cyc(0, 40'h0, 0, 0, 1, 1);
    chk("fl2 valid", 168'(bus_if.IF1_valid), 168'(1'b0));
    chk("fl2 ready", 168'(bus_if.IF1_ready), 168'(1'b1));
    chk("fl2 disc", 168'(dut.disc_q), 168'(2));
    cyc(1, 40'h0, 1, 32'hAA, 1, 0);
    chk("fl2 drop1 valid", 168'(bus_if.IF1_valid), 168'(1'b0));
    chk("fl2 drop1 disc", 168'(dut.disc_q), 168'(1));
    cyc(0, m(4'hF, 0, 32'h1c000200), 1, 32'hBB, 1, 0);
    chk("fl2 drop2 valid", 168'(bus_if.IF1_valid), 168'(1'b0));
    chk("fl2 drop2 disc", 168'(dut.disc_q), 168'(0));
    cyc(0, 40'h0, 1, 32'h50, 1, 0);
    chk_pkt("fl2 new", 32'h1c000200, 32'h50);
    cyc(0, 40'h0, 0, 0, 1, 0);
    chk("fl2 popped", 168'(bus_if.IF1_valid), 168'(1'b0));

    // Flush coincident with a response and a pending capture.
    cyc(1, 40'h0, 0, 0, 1, 0);
    cyc(1, m(4'hF, 0, 32'h1c000300), 0, 0, 1, 0);
    chk("flc pend ready", 168'(bus_if.IF1_ready), 168'(1'b0));
    cyc(0, m(4'hF, 0, 32'h1c000310), 1, 32'h60, 1, 1);
    chk("flc valid", 168'(bus_if.IF1_valid), 168'(1'b0));
    chk("flc disc", 168'(dut.disc_q), 168'(1));
    chk("flc ready", 168'(bus_if.IF1_ready), 168'(1'b1));
    cyc(0, 40'h0, 1, 32'h61, 1, 0);
    chk("flc drop valid", 168'(bus_if.IF1_valid), 168'(1'b0));
    chk("flc drop disc", 168'(dut.disc_q), 168'(0));
    cyc(1, 40'h0, 0, 0, 1, 0);
    cyc(0, m(4'hF, 0, 32'h1c000400), 0, 0, 1, 0);
    chk("flc no stale", 168'(bus_if.IF1_valid), 168'(1'b0));
    cyc(0, 40'h0, 1, 32'h70, 1, 0);
    chk_pkt("flc new", 32'h1c000400, 32'h70);
    cyc(0, 40'h0, 0, 0, 1, 0);
    chk("flc popped", 168'(bus_if.IF1_valid), 168'(1'b0));

    // Asynchronous reset while a packet is presented.
    cyc(1, 40'h0, 0, 0, 0, 0);
    cyc(0, m(4'hF, 0, 32'h1c000500), 0, 0, 0, 0);
    cyc(0, 40'h0, 1, 32'h80, 0, 0);
    chk_pkt("rst pre", 32'h1c000500, 32'h80);
    drive(0, 40'h0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst async valid", 168'(bus_if.IF1_valid), 168'(1'b0));
    chk("rst async bus", bus_if.if1_id_bus, 168'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst release ready", 168'(bus_if.IF1_ready), 168'(1'b1));

    // Asynchronous reset in DRAIN clears the discard count.
    cyc(1, 40'h0, 0, 0, 1, 0);
    cyc(0, m(4'hF, 0, 32'h1c000550), 0, 0, 1, 0);
    cyc(0, 40'h0, 0, 0, 1, 1);
    chk("drain disc", 168'(dut.disc_q), 168'(1));
    drive(0, 40'h0, 0, 0, 1, 0);
    #2 rst = 1'b1;
    #1;
    chk("drain rst disc", 168'(dut.disc_q), 168'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("drain rst ready", 168'(bus_if.IF1_ready), 168'(1'b1));
    cyc(1, 40'h0, 0, 0, 1, 0);
    cyc(0, m(4'hF, 0, 32'h1c000600), 0, 0, 1, 0);
    cyc(0, 40'h0, 1, 32'h90, 1, 0);
    chk_pkt("post rst", 32'h1c000600, 32'h90);
    cyc(0, 40'h0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage1.md
Name: if_stage1

Overview:
- Second fetch stage, directly downstream of the PC/request stage (IF0) and upstream of decode (ID).
- Pairs each accepted instruction-cache request's metadata (pc, per-slot valid and predicted-jump masks) with the in-order cache response (4 × 32-bit instructions).
- Holds results in a 2-entry in-order queue and presents fetch packets to ID with a valid/ready handshake.
- On flush, drops queued packets and discards cache responses still in flight.

Parameters:
- IF0_TO_IF1_BUS_WD, 40, width of the IF0 metadata bus: {pc_valid[3:0], pc_is_jump[3:0], pc[31:0]}.
- IF1_TO_ID_BUS_WD, 168, width of the packet to ID: {pc_valid[3:0], pc_is_jump[3:0], pc[31:0], inst3..inst0[127:0]}.
- QDEPTH, 2, fetch-queue entries; fixed at 2 in this revision.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush_IF  in  1  pipeline flush (branch redirect / exception).
- IF0_valid  in  1  IF0's request was accepted by the cache this cycle (addr_ok).
- IF1_ready  out  1  IF1 can accept a new request; gates IF0 PC advance.
- if0_if1_bus  in  IF0_TO_IF1_BUS_WD  request metadata, valid the cycle after acceptance.
- data_ok  in  1  cache response valid; responses arrive in request order.
- rdata  in  128  four instructions; inst0 in [31:0].
- IF1_valid  out  1  if1_id_bus holds a packet.
- if1_id_bus  out  IF1_TO_ID_BUS_WD  fetch packet.
- ID_ready  in  1  ID consumes the packet this cycle when IF1_valid is high.

Behaviour:
- Acceptance: a request is accepted at the edge where IF0_valid && IF1_ready && !flush_IF.
  - Registered flag cap_pend=1 marks the next cycle; in that cycle if0_if1_bus is captured into the queue tail with data_valid=0.
  - An incoming flush_IF in that cycle suppresses the capture.
- Queue entry fields: meta, data[127:0], data_valid.
  - Separate pointers: head, tail, and fill (oldest entry lacking data); used count 0..2.
- IF1_ready = (used + cap_pend) < 2. This guarantees every outstanding response has a slot, so data_ok is never back-pressured.
- data_ok while discard_cnt==0:
  - rdata is written into the fill-pointer entry; data_valid=1; fill advances.
  - data_ok with no entry awaiting data (and no discard pending) is a protocol error: assertion in simulation, ignored in RTL.
- Emit:
  - IF1_valid = head entry data_valid && head pc_valid!=0.
  - A head entry with data_valid && pc_valid==4'b0 (bubble) retires silently the next edge without asserting IF1_valid.
  - Head pops when IF1_valid && ID_ready.
  - Latency: data_ok at edge N gives IF1_valid in cycle N+1 if the entry is at head. No combinational path from data_ok or rdata to outputs.
- Simultaneous events in one cycle are all legal: pop, fill, and capture together.
  - Capture into a full queue cannot occur, guaranteed by IF1_ready.
- Flush (flush_IF=1 at an edge):
  - All entries and cap_pend are cleared.
  - discard_cnt += (entries with data_valid==0) + cap_pend, minus 1 if data_ok is high the same cycle; that response is dropped regardless.
- Discard: while discard_cnt>0, each data_ok decrements it and rdata is dropped.
  - IF1_ready is computed normally; discard responses never land in the queue because they arrive before any newer response (in-order cache).
- discard_cnt: 2 bits, saturates at 2 (max outstanding).
- FSM in one register:
  - NORMAL → DRAIN when a flush leaves discard_cnt>0.
  - DRAIN → NORMAL when discard_cnt reaches 0.
  - A new flush in DRAIN stays in DRAIN and adds to the count.
- Reset (asynchronous, any time including mid-transaction):
  - Queue empty; pointers 0; cap_pend=0; discard_cnt=0; FSM NORMAL.
  - IF1_valid=0, if1_id_bus=0, IF1_ready=1 once reset deasserts.
  - In-flight cache responses after reset are the cache's responsibility (the cache is reset simultaneously).

Decomposition:
- define.vh holds: IF0_TO_IF1_BUS_WD, IF1_TO_ID_BUS_WD, and field-offset macros for pc, is_jump, valid, inst slots.
- One sub-module, if1_fetch_queue: 2-entry meta+data queue with head/tail/fill pointers, used count, and flush-clear.
- if_stage1 contains only handshake, discard counter, and FSM.

Test Plan:
- Single fetch: accept pc=0x1c000000 with meta valid=4'hF, data_ok 3 cycles later, rdata=0x…03_02_01_00 → IF1_valid one cycle after data_ok; bus pc=0x1c000000, inst0=0x00; pops on ID_ready.
- Back-pressure: ID_ready=0, two requests answered → used=2, IF1_ready=0; third IF0_valid ignored; after one pop IF1_ready=1 and order is preserved (pc 0x1c000000 then 0x1c000010).
- Flush with two outstanding: two requests accepted, flush_IF before any data_ok → discard_cnt=2; next two data_ok dropped; third request's response emitted with its own pc.
- Flush coincident with data_ok and cap_pend → same-cycle response dropped, discard_cnt correct, no stale packet reaches ID.
- Bubble meta (pc_valid=0) → response consumed, IF1_valid never asserted, next packet emitted normally.
- Async reset asserted mid-DRAIN with IF1_valid=1 → outputs zero immediately, IF1_ready=1 after release.
